// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
//   Owns the architectural PC. Keeps at most one imem request outstanding,
//   latches the response, and presents it to decode over valid/ready.
//   When a branch/jalr redirect arrives, the sequencer loads the new PC.
//   Any response still in flight at that point is discarded through a kill flag.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   When defined, a misaligned redirect target parks the sequencer in FAULT.
//   In FAULT, fetch_misalign is raised and no requests are issued until an
//   aligned redirect arrives. When undefined, targets are force-aligned.
// Ports:
//   clk, rst             core clock, synchronous active-low reset
//   redirect_valid/target taken branch/jal/jalr and its target PC
//   imem_req_*           fetch request (valid/ready/addr)
//   imem_resp_*          fetch response (valid/data), in order
//   inst_*               decoded-stage handshake (valid/ready/data/pc)
//   pc_now               current fetch PC register
//   fetch_misalign       (feature only) sticky misaligned-target flag
module fetch_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            fetch_misalign,
`endif
  output logic [XLEN-1:0] pc_now
);

  localparam logic [2:0] S_BOOT  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_OUT   = 3'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam logic [2:0] S_FAULT = 3'd4;
`endif

  logic [2:0]      r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_kill;
  logic [31:0]     r_inst_data;
  logic [XLEN-1:0] r_inst_pc;

  logic            w_hs;
  logic [XLEN-1:0] w_tgt;
  logic [2:0]      w_redir_st;  // where a redirect sends us
  logic [2:0]      w_drain_st;  // where a drained (killed) response sends us

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;
  logic w_bad;
  assign w_bad      = |redirect_target[1:0];
  assign w_tgt      = redirect_target;
  assign w_redir_st = w_bad ? S_FAULT : S_REQ;
  assign w_drain_st = r_misalign ? S_FAULT : S_REQ;
  assign fetch_misalign = r_misalign;
`else
  assign w_tgt      = {redirect_target[XLEN-1:2], 2'b00};
  assign w_redir_st = S_REQ;
  assign w_drain_st = S_REQ;
`endif

  assign imem_req_valid = (r_state == S_REQ);
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (r_state == S_OUT);
  assign inst_data      = r_inst_data;
  assign inst_pc        = r_inst_pc;
  assign pc_now         = r_pc;
  assign w_hs           = imem_req_valid & imem_req_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_BOOT;
      r_pc        <= RESET_PC;
      r_kill      <= 1'b0;
      r_inst_data <= '0;
      r_inst_pc   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      // Redirect always wins the PC; the state-specific pc+4 below is
      // only taken when no redirect is present.
      if (redirect_valid) begin
        r_pc <= w_tgt;
`ifdef FETCH_MISALIGN_TRAP_EN
        r_misalign <= w_bad;
`endif
      end
      case (r_state)
        S_BOOT: r_state <= redirect_valid ? w_redir_st : S_REQ;
        S_REQ: begin
          if (w_hs) begin
            // The old address goes out; a same-cycle redirect must discard its response.
            r_state <= S_WAIT;
            r_kill  <= redirect_valid;
          end else if (redirect_valid) begin
            r_state <= w_redir_st;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            r_kill <= 1'b0;
            if (redirect_valid) begin
              r_state <= w_redir_st;
            end else if (r_kill) begin
              r_state <= w_drain_st;
            end else begin
              r_inst_data <= imem_resp_data;
              r_inst_pc   <= r_pc;
              r_state     <= S_OUT;
            end
          end else if (redirect_valid) begin
            r_kill <= 1'b1;
          end
        end
        S_OUT: begin
          if (redirect_valid) begin
            r_state <= w_redir_st;
          end else if (inst_ready) begin
            r_pc    <= r_pc + XLEN'(4);
            r_state <= S_REQ;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_FAULT: if (redirect_valid) r_state <= w_redir_st;
`endif
        default: r_state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. The bench keeps a transaction-level
// reference model with the following pieces:
//   - the expected fetch PC,
//   - the single outstanding imem request (address, latency, killed),
//   - the instruction owed to decode.
// The bench derives every expectation from those pieces.
module tb_fetch_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] pc_now;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign;
`endif

  fetch_ctrl #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign(fetch_misalign),
`endif
    .pc_now(pc_now)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [31:0] exp_pc;
  bit          in_boot, m_out, m_kill, pend, fault;
  int          m_lat, next_lat, xfers;
  logic [31:0] m_addr, pend_pc, pend_data;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[31:2], 2'b00};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RPC; in_boot = 1; m_out = 0; m_kill = 0; pend = 0; fault = 0; m_lat = 0;
  endtask

  // One clock: drive at the negedge, check #1 later, update the model at the posedge.
  task automatic step(input bit rv, input logic [31:0] tgt, input bit ir, input bit qr);
    bit hs, xfer, resp, exp_req;
    logic [31:0] s_addr;
    redirect_valid  = rv;
    redirect_target = tgt;
    inst_ready      = ir;
    imem_req_ready  = qr;
    imem_resp_valid = m_out && (m_lat == 0);
    imem_resp_data  = m_out ? mem(m_addr) : $urandom;
    #1;
    exp_req = !in_boot && !m_out && !pend && !fault;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    chk("pc_now", pc_now, exp_pc);
    if (exp_req) chk("req_addr", imem_req_addr, exp_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, pend});
    if (pend) begin
      chk("inst_pc", inst_pc, pend_pc);
      chk("inst_data", inst_data, pend_data);
    end
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign", {31'b0, fetch_misalign}, {31'b0, fault});
`endif
    hs = imem_req_valid && qr;
    xfer = inst_valid && ir;
    resp = imem_resp_valid;
    s_addr = imem_req_addr;
    @(posedge clk);
    in_boot = 0;
    if (xfer) xfers++;
    if (resp) begin
      m_out = 0;
      if (!m_kill && !rv) begin
        pend = 1; pend_pc = m_addr; pend_data = mem(m_addr);
      end
    end else if (m_out) begin
      m_lat--;
    end
    if (hs) begin
      m_out = 1; m_addr = s_addr; m_kill = 0; m_lat = next_lat;
    end
    if (rv) begin
      exp_pc = align(tgt);
      if (m_out) m_kill = 1;
      pend = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault = |tgt[1:0];
`endif
    end else if (xfer) begin
      exp_pc = exp_pc + 32'd4;
      pend = 0;
    end
    @(negedge clk);
  endtask

  task automatic run_until_out();
    int n = 0;
    while (!m_out && n < 20) begin step(0, 0, 1, 1); n++; end
    chk("wait_out_bound", {31'b0, m_out}, 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_pc_now", pc_now, RPC);
  endtask

  initial begin
    rst = 0; redirect_valid = 0; redirect_target = 0; imem_req_ready = 0;
    imem_resp_valid = 0; imem_resp_data = 0; inst_ready = 0;
    next_lat = 0; xfers = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1;

    // Sequential fetch with 1-cycle memory and decode always ready.
    repeat (12) step(0, 0, 1, 1);
    chk("seq_xfers", xfers, 3);

    // Decode stalls 3 cycles.
    while (!pend) step(0, 0, 1, 1);
    repeat (3) step(0, 0, 0, 1);
    repeat (4) step(0, 0, 1, 1);

    // Redirect in WAIT; response lands two cycles later and must vanish.
    next_lat = 2;
    run_until_out();
    step(1, 32'h0000_0100, 1, 1);
    next_lat = 0;
    repeat (8) step(0, 0, 1, 1);

    // Redirect in the same cycle as the response.
    run_until_out();
    step(1, 32'h0000_0200, 1, 1);
    repeat (6) step(0, 0, 1, 1);

    // Wrap-around from the top of the address space.
    step(1, 32'hFFFF_FFFC, 1, 1);
    repeat (10) step(0, 0, 1, 1);
    chk("wrap_pc", exp_pc[31:12], 20'h0);

    // Misaligned redirect target.
    step(1, 32'h0000_0102, 1, 1);
    repeat (6) step(0, 0, 1, 1);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fault_held", {31'b0, fetch_misalign}, 32'd1);
    step(1, 32'h0000_0400, 1, 1);
    repeat (6) step(0, 0, 1, 1);
`endif

    // Reset mid-transaction.
    run_until_out();
    rst = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    model_reset();
    check_reset_values();
    rst = 1;

    // Randomized traffic.
    xfers = 0;
    for (int i = 0; i < 3000; i++) begin
      next_lat = int'($urandom_range(0, 3));
      step(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0));
`ifdef FETCH_MISALIGN_TRAP_EN
      if (fault && $urandom_range(0, 3) == 0) step(1, {$urandom_range(0, 32'hFFFF), 2'b00}, 1, 1);
`endif
    end
    chk("random_progress", {31'b0, xfers > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer that owns the architectural PC and drives the next-PC adder output into a single-outstanding instruction-memory request stream.
- Issues fetch requests, captures responses, hands instructions to decode over a valid/ready handshake, and applies branch/jalr redirects.
- Any response already in flight when a redirect arrives is discarded.
- Sits between the next-PC adder, the imem bus port and the decode stage.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous reset, active-low
- redirect_valid  input  1  taken branch/jal/jalr this cycle
- redirect_target  input  XLEN  new PC (next-PC adder output)
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  imem accepts request
- imem_req_addr  output  XLEN  fetch address (= pc)
- imem_resp_valid  input  1  response data valid
- imem_resp_data  input  32  fetched instruction word
- inst_valid  output  1  instruction available to decode
- inst_ready  input  1  decode accepts instruction
- inst_data  output  32  instruction word
- inst_pc  output  XLEN  PC of inst_data
- pc_now  output  XLEN  current fetch PC register

Behaviour:
- Reset (rst==0 at posedge):
  - pc=RESET_PC, state=BOOT, kill=0.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - Reset mid-transaction abandons everything. Any later imem response is not counted; the imem side is reset together with the core.
- States: BOOT, REQ, WAIT, OUT.
- BOOT: outputs idle for one cycle, then -> REQ.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - imem_req_valid&imem_req_ready -> WAIT.
  - The address is sampled only on the handshake. It may change while the request is not yet accepted.
- WAIT:
  - On imem_resp_valid with kill=0: latch inst_data=imem_resp_data and inst_pc=pc, then -> OUT.
  - On imem_resp_valid with kill=1: drop the response, kill<=0, -> REQ.
- OUT:
  - inst_valid=1; inst_data and inst_pc held stable until accepted.
  - On inst_valid&inst_ready: pc<=pc+4, -> REQ.
  - Handshake-to-next-request latency is 1 cycle.
- Redirect has priority over every other event in the same cycle:
  - BOOT: pc<=target; still -> REQ.
  - REQ, no handshake this cycle: pc<=target, stay REQ. The new address is driven next cycle.
  - REQ, handshake this cycle: the old-address request is issued; pc<=target, kill<=1, -> WAIT.
  - WAIT, no resp this cycle: pc<=target, kill<=1, stay WAIT.
  - WAIT, resp this cycle: drop the response, pc<=target, kill<=0, -> REQ.
  - OUT: inst_valid drops next cycle, pc<=target, -> REQ. If inst_ready is also high, the transfer counts for decode, but no +4 is applied.
- Arithmetic: pc+4 wraps modulo 2^XLEN; 32'hFFFF_FFFC+4 = 0.
- Ordering: at most one request outstanding; responses arrive in order. Total fetch latency = 1 (REQ) + imem latency + 1 (OUT).
- Alignment handling without the optional feature: redirect_target[1:0] is forced to 2'b00 when loaded.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- When defined:
  - Extra output fetch_misalign (1 bit, reset 0) and extra state FAULT.
  - A redirect with target[1:0]!=0 loads pc unmodified and sets fetch_misalign=1, then -> FAULT (after the kill drain if a request is outstanding).
  - FAULT issues no requests and no instructions.
  - An aligned redirect clears fetch_misalign and -> REQ.
- When undefined: no port, no FAULT state, targets are force-aligned.

Test Plan:
- Reset release, imem ready always, 1-cycle response:
  - -> first request at addr 32'h8000_0000 on the 2nd cycle after reset.
  - -> inst_pc sequence 8000_0000, 8000_0004, 8000_0008 with decode always ready.
- Decode stalls 3 cycles in OUT:
  - -> inst_valid, inst_data, inst_pc constant for all 3 cycles.
  - -> no new imem request until the cycle after inst_ready.
- Redirect to 32'h0000_0100 in WAIT, response 2 cycles later:
  - -> that response never appears on inst_valid.
  - -> next request addr 32'h0000_0100.
- Redirect in the same cycle as imem_resp_valid:
  - -> response dropped, kill stays 0.
  - -> next request addr = target.
- Redirect to 32'hFFFF_FFFC, then sequential fetch:
  - -> requests FFFF_FFFC then 0000_0000.
- Redirect target 32'h0000_0102:
  - -> without macro, request addr 32'h0000_0100.
  - -> with FETCH_MISALIGN_TRAP_EN, fetch_misalign=1 and no further requests until an aligned redirect.
